imem_dump_tx: RTL and testbench
===============================

# imem_dump_tx

Debug readback transmitter for the 5-stage RISC-V core. On command it reads a range of 32-bit words from instruction memory and streams them out as bytes over a valid/ready interface. Bytes go out in the same big-endian order used when the memory is loaded: MSB first, so byte address 4k holds bits 31:24 of word k. A trailing checksum byte lets the bench or host confirm that the image in RAM matches the image it loaded.

## Interface
Parameters:
- ADDR_W, 8: byte-address width of instruction memory (256 B).
- CNT_W, 7: width of the word-count field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] ignored (forced 0).
- word_count  in  CNT_W  number of words to dump; 0 is legal.
- busy  out  1  high from start accept until the cycle done pulses.
- done  out  1  one-cycle pulse at completion.
- mem_rd_en  out  1  read strobe to instruction memory.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_rdata  in  32  read data, valid 1 cycle after mem_rd_en; {RAM[a], RAM[a+1], RAM[a+2], RAM[a+3]}.
- tx_valid  out  1  byte available.
- tx_ready  in  1  consumer accepts the byte when tx_valid && tx_ready.
- tx_data  out  8  byte.
- tx_last  out  1  high with the checksum byte only.

## Operation
FSM states:
- IDLE
  - start=1, word_count≠0: latch base_addr & ~3 into addr_q and word_count into rem_q; clear csum; go to RD.
  - start=1, word_count=0: go to CSUM directly, with csum = 0.
- RD: mem_rd_en=1, mem_addr=addr_q; go to WT.
- WT: capture mem_rdata into word_q; byte_idx=0; go to TX.
- TX
  - tx_valid=1, tx_data=word_q[31-8*byte_idx -: 8].
  - On handshake: csum += tx_data (mod 256) and byte_idx++.
  - On handshake with byte_idx=3: addr_q += 4 (wraps mod 2^ADDR_W) and rem_q--. If the new rem_q = 0 go to CSUM, else go to RD.
- CSUM: tx_valid=1, tx_data = (~csum)+1 (two's complement, so the sum of all emitted bytes ≡ 0 mod 256), tx_last=1. On handshake go to DONE.
- DONE: done=1 for one cycle; go to IDLE.

Rules:
- busy = (state ≠ IDLE) && (state ≠ DONE).
- start is ignored outside IDLE.
- tx_data, tx_last and tx_valid hold stable while tx_valid && !tx_ready. Valid is never withdrawn before its handshake.
- mem_rd_en is high only in RD. mem_addr holds addr_q at all times.

## Timing
- Reset (reset=0 at a clock edge) forces the following, including mid-dump. Any in-flight byte is dropped.
  - State goes to IDLE.
  - busy, done, mem_rd_en, tx_valid and tx_last go to 0.
  - tx_data, mem_addr, csum and counters go to 0.
- With start high at edge N:
  - mem_rd_en is high in cycle N+1.
  - tx_valid rises at N+3 (1 cycle RD, 1 cycle WT).
- Per word with tx_ready held 1: 6 cycles (RD, WT, 4×TX).
- Total for W words with tx_ready=1: 6W + 1 (CSUM) + 1 (DONE) cycles after the start edge before returning to IDLE.
- Zero-count dump: CSUM in N+1 emitting 0x00 with tx_last, then done in N+2.
- Backpressure stalls only TX and CSUM. No memory read is issued while a byte is pending.

## Test plan
- Reset mid-TX: hold tx_ready=0 during a dump and assert reset → next cycle tx_valid=0, busy=0, mem_rd_en=0. A new start is accepted normally afterwards.
- Single word: RAM[4..7]=00,21,01,33; base_addr=4, word_count=1, tx_ready=1.
  - tx stream is 00,21,01,33 then 0xAB (last).
  - busy is high for 7 cycles and done pulses once.
- Multi-word with random tx_ready (~50% duty): 12 words from base 4 → every byte matches RAM in address order, bytes are stable during stalls, and the byte sum including the checksum ≡ 0.
- Wrap-around: ADDR_W=8, base_addr=0xFC, word_count=2 → reads at 0xFC then 0x00. Emits RAM[252..255], RAM[0..3], then the checksum.
- Count zero and misaligned base: word_count=0 → a single 0x00 byte with tx_last, then done. base_addr=0x06, count=1 → reads 0x04.
- start while busy: pulse start during TX with different arguments → ignored, and the original dump completes unchanged.

Source files
------------

// File: rtl/imem_dump_tx.sv
// imem_dump_tx: streams a range of instruction-memory words out as bytes
// (MSB first) and follows them with a two's-complement checksum byte.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   start             one-cycle dump request (sampled in IDLE only)
//   base_addr         byte address of first word (low 2 bits ignored)
//   word_count        words to dump, 0 allowed
//   busy / done       activity flag / one-cycle completion pulse
//   mem_rd_en         read strobe, mem_rdata valid one cycle later
//   mem_addr          word-aligned byte address (always addr_q)
//   mem_rdata         {RAM[a], RAM[a+1], RAM[a+2], RAM[a+3]}
//   tx_valid/ready    byte handshake
//   tx_data           byte payload
//   tx_last           marks the checksum byte
module imem_dump_tx #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_TX,
    S_CSUM,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  rem_q;
  logic [7:0]        csum_q;
  logic [31:0]       word_q;
  logic [1:0]        byte_idx;
  logic [7:0]        tx_byte;
  logic              hs;
  logic              word_end;
  logic              cnt_zero;

  assign hs       = tx_valid & tx_ready;
  assign word_end = (state_q == S_TX) & hs
                  & (byte_idx == 2'd3);
  assign cnt_zero = (word_count == '0);
  assign mem_addr = addr_q;

  // MSB-first byte select
  always_comb begin
    tx_byte = 8'h00;
    unique case (byte_idx)
      2'd0: tx_byte = word_q[31:24];
      2'd1: tx_byte = word_q[23:16];
      2'd2: tx_byte = word_q[15:8];
      2'd3: tx_byte = word_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start)
          state_d = cnt_zero ? S_CSUM : S_RD;
      end
      S_RD: state_d = S_WT;
      S_WT: state_d = S_TX;
      S_TX: begin
        if (word_end)
          state_d = (rem_q == CNT_W'(1))
                  ? S_CSUM : S_RD;
      end
      S_CSUM: begin
        if (hs) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_last   = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_RD: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
      end
      S_WT: busy = 1'b1;
      S_TX: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = tx_byte;
      end
      S_CSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = (~csum_q) + 8'd1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: only moves on handshakes so the
  // presented byte holds steady under backpressure.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q   <= '0;
      rem_q    <= '0;
      csum_q   <= '0;
      word_q   <= '0;
      byte_idx <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            csum_q <= '0;
            if (!cnt_zero) begin
              addr_q <= base_addr & ~ADDR_W'(3);
              rem_q  <= word_count;
            end
          end
        end
        S_WT: begin
          word_q   <= mem_rdata;
          byte_idx <= '0;
        end
        S_TX: begin
          if (hs) begin
            csum_q   <= csum_q + tx_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              addr_q <= addr_q + ADDR_W'(4);
              rem_q  <= rem_q - CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_dump_tx.sv
// tb_imem_dump_tx: directed bench for imem_dump_tx
// with a byte-array RAM model behind the read port.
module tb_imem_dump_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_last;

  logic [7:0] ram [256];

  int compared = 0;
  int mismatched = 0;

  logic [7:0] got_d [$];
  logic       got_l [$];
  logic [7:0] rd_q  [$];
  logic [7:0] exp_q [$];
  int busy_cyc;
  int done_cnt;
  int stall_err;
  int first_valid;
  bit timed_out;

  imem_dump_tx #(.ADDR_W(8), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_last    (tx_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en)
      mem_rdata <= {ram[mem_addr],
                    ram[mem_addr + 8'd1],
                    ram[mem_addr + 8'd2],
                    ram[mem_addr + 8'd3]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Run one dump; inj >= 0 pulses a conflicting
  // start at that cycle index.
  task automatic run_dump(input logic [7:0] base,
                          input logic [6:0] wc,
                          input bit rnd,
                          input int inj);
    logic       pstall;
    logic [7:0] pdata;
    logic       plast;
    got_d.delete();
    got_l.delete();
    rd_q.delete();
    busy_cyc = 0;
    done_cnt = 0;
    stall_err = 0;
    first_valid = -1;
    timed_out = 1'b1;
    pstall = 1'b0;
    pdata = 8'h00;
    plast = 1'b0;
    base_addr = base;
    word_count = wc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == inj) begin
        start = 1'b1;
        base_addr = 8'h80;
        word_count = 7'd3;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cyc++;
      if (mem_rd_en) rd_q.push_back(mem_addr);
      if (tx_valid && first_valid < 0)
        first_valid = cyc;
      if (pstall && (!tx_valid ||
          tx_data !== pdata || tx_last !== plast))
        stall_err++;
      if (tx_valid && tx_ready) begin
        got_d.push_back(tx_data);
        got_l.push_back(tx_last);
      end
      pstall = tx_valid && !tx_ready;
      pdata = tx_data;
      plast = tx_last;
      if (done) begin
        done_cnt++;
        timed_out = 1'b0;
        start = 1'b0;
        tick();
        break;
      end
      tick();
    end
    tx_ready = 1'b1;
    chk("timeout", 32'(timed_out), 32'd0);
  endtask

  task automatic expect_stream(input string tag,
                               input logic [7:0] base,
                               input int wc);
    logic [7:0] a;
    logic [7:0] s;
    logic [7:0] cs;
    int n;
    exp_q.delete();
    a = base & 8'hFC;
    s = 8'h00;
    for (int w = 0; w < wc; w++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(ram[a + 8'(b)]);
        s = s + ram[a + 8'(b)];
      end
      a = a + 8'd4;
    end
    cs = (~s) + 8'd1;
    exp_q.push_back(cs);
    chk({tag, " len"}, 32'(got_d.size()),
        32'(exp_q.size()));
    n = (got_d.size() < exp_q.size())
      ? got_d.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s byte%0d", tag, i),
          32'(got_d[i]), 32'(exp_q[i]));
    n = 0;
    s = 8'h00;
    foreach (got_l[i]) if (got_l[i]) n++;
    foreach (got_d[i]) s = s + got_d[i];
    chk({tag, " lastcnt"}, 32'(n), 32'd1);
    if (got_l.size() > 0)
      chk({tag, " lastpos"}, 32'(got_l[$]), 32'd1);
    chk({tag, " sum0"}, 32'(s), 32'd0);
    chk({tag, " stall"}, 32'(stall_err), 32'd0);
    chk({tag, " done"}, 32'(done_cnt), 32'd1);
    chk({tag, " donelow"}, 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      ram[i] = 8'(i * 37 + 11);
    ram[4] = 8'h00;
    ram[5] = 8'h21;
    ram[6] = 8'h01;
    ram[7] = 8'h33;
    mem_rdata = 32'h0;
    reset = 1'b0;
    start = 1'b0;
    base_addr = 8'h00;
    word_count = 7'd0;
    tx_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst valid", 32'(tx_valid), 32'd0);
    chk("rst last", 32'(tx_last), 32'd0);
    chk("rst data", 32'(tx_data), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    reset = 1'b1;
    tick();

    // Reset mid-TX with backpressure
    tx_ready = 1'b0;
    base_addr = 8'h04;
    word_count = 7'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mtx rd_en", 32'(mem_rd_en), 32'd1);
    chk("mtx addr", 32'(mem_addr), 32'h04);
    tick();
    tick();
    tick();
    chk("mtx pend", 32'(tx_valid), 32'd1);
    chk("mtx data", 32'(tx_data), 32'h00);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tx_ready = 1'b1;
    chk("mtx valid", 32'(tx_valid), 32'd0);
    chk("mtx busy", 32'(busy), 32'd0);
    chk("mtx rd_en0", 32'(mem_rd_en), 32'd0);
    chk("mtx addr0", 32'(mem_addr), 32'd0);

    // Single word, hand-computed stream
    run_dump(8'h04, 7'd1, 1'b0, -1);
    expect_stream("one", 8'h04, 1);
    if (got_d.size() == 5) begin
      chk("one b0", 32'(got_d[0]), 32'h00);
      chk("one b1", 32'(got_d[1]), 32'h21);
      chk("one b2", 32'(got_d[2]), 32'h01);
      chk("one b3", 32'(got_d[3]), 32'h33);
      chk("one cs", 32'(got_d[4]), 32'hAB);
    end
    chk("one busy", 32'(busy_cyc), 32'd7);
    chk("one fvld", 32'(first_valid), 32'd2);
    chk("one rds", 32'(rd_q.size()), 32'd1);

    // Multi-word, random backpressure
    run_dump(8'h04, 7'd12, 1'b1, -1);
    expect_stream("multi", 8'h04, 12);
    chk("multi rds", 32'(rd_q.size()), 32'd12);

    // Address wrap
    run_dump(8'hFC, 7'd2, 1'b0, -1);
    expect_stream("wrap", 8'hFC, 2);
    chk("wrap rds", 32'(rd_q.size()), 32'd2);
    if (rd_q.size() == 2) begin
      chk("wrap rd0", 32'(rd_q[0]), 32'hFC);
      chk("wrap rd1", 32'(rd_q[1]), 32'h00);
    end
    chk("wrap busy", 32'(busy_cyc), 32'd13);

    // Zero count
    run_dump(8'h40, 7'd0, 1'b0, -1);
    chk("zero len", 32'(got_d.size()), 32'd1);
    if (got_d.size() == 1) begin
      chk("zero byte", 32'(got_d[0]), 32'h00);
      chk("zero last", 32'(got_l[0]), 32'd1);
    end
    chk("zero fvld", 32'(first_valid), 32'd0);
    chk("zero busy", 32'(busy_cyc), 32'd1);
    chk("zero done", 32'(done_cnt), 32'd1);
    chk("zero rds", 32'(rd_q.size()), 32'd0);

    // Misaligned base
    run_dump(8'h06, 7'd1, 1'b0, -1);
    expect_stream("mis", 8'h06, 1);
    chk("mis rds", 32'(rd_q.size()), 32'd1);
    if (rd_q.size() == 1)
      chk("mis rd0", 32'(rd_q[0]), 32'h04);

    // Start while busy is ignored
    run_dump(8'h10, 7'd2, 1'b0, 4);
    expect_stream("ign", 8'h10, 2);
    chk("ign rds", 32'(rd_q.size()), 32'd2);
    chk("ign idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
